// File: rtl/seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - DEFAULT_WIDTH : default operand width in bits
//   - state_t       : FSM state type, with the IDLE / CALC / FIX encodings
// ---------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Radix-2 sequential multiplier, one multiplier bit per clock, with an
// optional two's-complement mode handled as sign/magnitude around an
// unsigned core.
//
// Ports:
//   clk            : clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   start          : request a multiply (only looked at while idle)
//   signed_mode    : 1 = two's-complement operands/result, 0 = unsigned
//   a              : multiplicand  [WIDTH-1:0]
//   b_in           : multiplier    [WIDTH-1:0]
//   busy           : high while an operation is in flight
//   rdy            : one-cycle pulse, multiplier_out valid
//   multiplier_out : registered product [2*WIDTH-1:0], held until next rdy
//
// Latency: start sampled in cycle 0 -> busy in cycles 1..WIDTH+1,
// rdy in cycle WIDTH+2 (FSM already idle, so a new start is accepted there).
// ---------------------------------------------------------------------------
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 rdy,
    output logic [2*WIDTH-1:0]   multiplier_out
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits because the result is treated as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                    input logic           is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && v[WIDTH-1]) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of the full-width product.
    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*WIDTH-1:0]  mcand_r;   // multiplicand magnitude, shifted left each step
    logic [WIDTH-1:0]    mplier_r;  // multiplier magnitude, shifted right each step
    logic [2*WIDTH-1:0]  acc_r;
    logic                neg_r;     // result must be negated in FIX
    logic                busy_r;
    logic                rdy_r;
    logic [2*WIDTH-1:0]  prod_r;
    logic [2*WIDTH-1:0]  acc_next_s;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            rdy_r    <= 1'b0;
            prod_r   <= '0;
        end else begin
            rdy_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                        mplier_r <= magnitude(b_in, signed_mode);
                        neg_r    <= signed_mode & (a[WIDTH-1] ^ b_in[WIDTH-1]);
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CALC;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    prod_r  <= neg_r ? negate(acc_r) : acc_r;
                    rdy_r   <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign rdy            = rdy_r;
    assign multiplier_out = prod_r;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier (WIDTH=16). A cycle-level model
// (countdown to rdy + arithmetic product) is compared against busy, rdy and
// multiplier_out on every cycle; directed scenarios add literal checks of
// values and rdy cycle numbers.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b_in = '0;
    logic           busy;
    logic           rdy;
    logic [2*W-1:0] multiplier_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .signed_mode    (signed_mode),
        .a              (a),
        .b_in           (b_in),
        .busy           (busy),
        .rdy            (rdy),
        .multiplier_out (multiplier_out)
    );

    always #5 clk = ~clk;

    // Reference product from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic sm);
        longint sx, sy, p;
        sx = sm ? longint'($signed(x)) : longint'(x);
        sy = sm ? longint'($signed(y)) : longint'(y);
        p  = sx * sy;
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start yields rdy WIDTH+2 cycles later.
    int             m_rem = 0;
    logic           m_busy = 1'b0;
    logic           m_rdy = 1'b0;
    logic [2*W-1:0] m_out = '0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_out  <= '0;
        end else begin
            m_rdy <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_rdy  <= 1'b1;
                    m_out  <= m_pend;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                m_rem  <= W + 1;
                m_pend <= ref_mul(a, b_in, signed_mode);
                m_busy <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", 64'(busy), 64'(m_busy));
            chk("model_rdy",  64'(rdy),  64'(m_rdy));
            chk("model_out",  64'(multiplier_out), 64'(m_out));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Drive start for one cycle, then scramble the operand inputs.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        start = 1'b1; a = x; b_in = y; signed_mode = sm;
        step();
        start = 1'b0;
        a = W'($urandom); b_in = W'($urandom); signed_mode = 1'($urandom);
    endtask

    // Wait (bounded) for rdy; c counts the cycle number since the start cycle.
    task automatic wait_rdy(input int c0, output int c);
        c = c0;
        while (!rdy && c < 40) begin
            step();
            c++;
        end
        if (!rdy) chk("rdy_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sm, input logic [2*W-1:0] exp_v);
        int c;
        launch(x, y, sm);
        wait_rdy(1, c);
        chk({nm, "_cycle"}, 64'(c), 64'(W + 2));
        chk({nm, "_val"}, 64'(multiplier_out), 64'(exp_v));
    endtask

    task automatic count_rdy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (rdy) cnt++;
        end
    endtask

    initial begin
        int c;
        int nr;
        logic [W-1:0] corners [5];
        corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
        corners[3] = 16'h8000; corners[4] = 16'hFFFF;

        rst = 1'b1;
        step(); step();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rdy",  64'(rdy),  64'(0));
        chk("reset_out",  64'(multiplier_out), 64'(0));
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Unsigned 3x5, with busy verified on every cycle of the operation.
        launch(16'd3, 16'd5, 1'b0);
        c = 1;
        while (!rdy && c < 40) begin
            chk("busy_window", 64'(busy), 64'(1));
            step();
            c++;
        end
        chk("u3x5_cycle", 64'(c), 64'(18));
        chk("u3x5_val",   64'(multiplier_out), 64'h0000000F);
        chk("u3x5_busy_in_rdy", 64'(busy), 64'(0));

        run_op("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        run_op("s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        run_op("sm3x7",      16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
        run_op("s8000x1",    16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        run_op("u8000x8000", 16'h8000, 16'h8000, 1'b0, 32'h40000000);

        // Start while busy is ignored.
        launch(16'd2, 16'd3, 1'b0);
        repeat (4) step();
        start = 1'b1; a = 16'd9; b_in = 16'd9;
        step();
        start = 1'b0;
        wait_rdy(6, c);
        chk("ignore_cycle", 64'(c), 64'(18));
        chk("ignore_val",   64'(multiplier_out), 64'd6);
        count_rdy(25, nr);
        chk("ignore_no_second_rdy", 64'(nr), 64'(0));

        // Reset in cycle 8 aborts the operation.
        launch(16'd77, 16'd33, 1'b0);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rdy",  64'(rdy),  64'(0));
        chk("abort_out",  64'(multiplier_out), 64'(0));
        count_rdy(25, nr);
        chk("abort_no_rdy", 64'(nr), 64'(0));
        run_op("u4x4", 16'd4, 16'd4, 1'b0, 32'd16);

        // Start together with reset is ignored.
        rst = 1'b1; start = 1'b1; a = 16'd5; b_in = 16'd5;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst_start_busy", 64'(busy), 64'(0));

        // Back-to-back: start accepted in the rdy cycle.
        launch(16'd1, 16'd1, 1'b0);
        wait_rdy(1, c);
        chk("b2b_first_cycle", 64'(c), 64'(18));
        chk("b2b_first_val",   64'(multiplier_out), 64'd1);
        launch(16'd2, 16'd2, 1'b0);
        wait_rdy(1, c);
        chk("b2b_second_cycle", 64'(c + 18), 64'(36));
        chk("b2b_second_val",   64'(multiplier_out), 64'd4);

        // Random traffic, including corner operands and rare resets.
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            signed_mode = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            b_in = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0;
        repeat (25) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new multiply; sampled only in IDLE.
REQ-005 SHALL have port signed_mode, input, 1 bit: 1 selects two's-complement operands and result, 0 selects unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand; sampled with start.
REQ-007 SHALL have port b_in, input, WIDTH bits: multiplier; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port rdy, output, 1 bit: one-cycle pulse marking multiplier_out valid.
REQ-010 SHALL have port multiplier_out, output, 2*WIDTH bits: product, registered, held until the next rdy.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and FIX; reset state is IDLE.
REQ-012 IDLE with start=1 SHALL capture operands and mode, clear the accumulator, load step counter 0, and go to CALC.
REQ-013 In signed mode, capture SHALL store operand magnitudes as WIDTH-bit unsigned values, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
REQ-014 Capture SHALL record the result sign as sign(a) XOR sign(b_in).
REQ-015 Each CALC cycle SHALL perform one radix-2 shift-add step on one multiplier bit, LSB first, into a 2*WIDTH-bit accumulator, then increment the counter.
REQ-016 After WIDTH CALC cycles, the FSM SHALL go to FIX.
REQ-017 FIX SHALL write multiplier_out with the accumulator, two's-complement negated when signed_mode=1 and the result sign is negative; it SHALL set rdy=1 and return to IDLE.
REQ-018 Timing: when start is sampled in cycle 0, busy SHALL be high in cycles 1..WIDTH+1, and rdy high and busy low in cycle WIDTH+2.
REQ-019 rdy SHALL be high for exactly one cycle per accepted start.
REQ-020 start SHALL be ignored while busy=1; no queuing, and the operation in flight is unaffected.
REQ-021 start high in the rdy cycle SHALL be accepted, because the FSM is already in IDLE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-022 Operand changes on a/b_in/signed_mode after capture SHALL NOT affect the result in progress.
REQ-023 The product SHALL be exact for all operand pairs in both modes, with no overflow at 2*WIDTH bits.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, rdy=0, multiplier_out=0, and clear the accumulator, counter and captured operands on the next clock edge.
REQ-025 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL NOT produce rdy.
REQ-026 start sampled together with rst=1 SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (IDLE/CALC/FIX) and the default WIDTH constant.
REQ-028 The step counter width SHALL be derived as clog2(WIDTH+1) inside the module.
REQ-029 The design SHALL be a single module with no sub-modules; the optional sign-fix negation may be a local function.

Verification (WIDTH=16)
REQ-030 Unsigned 3 x 5, start in cycle 0 -> rdy only in cycle 18, multiplier_out=0x0000000F, busy high cycles 1..17.
REQ-031 Unsigned 0xFFFF x 0xFFFF -> multiplier_out=0xFFFE0001; signed 0x8000 x 0x8000 -> 0x40000000.
REQ-032 Signed 0xFFFD (-3) x 0x0007 -> 0xFFFFFFEB (-21); signed 0x8000 x 0x0001 -> 0xFFFF8000.
REQ-033 Start 2 x 3, then start 9 x 9 pulsed in cycle 5 -> single rdy in cycle 18 with result 6; no second rdy.
REQ-034 rst=1 in cycle 8 of an operation -> busy=0, rdy=0, multiplier_out=0 in cycle 9, no rdy follows; a new 4 x 4 then yields 16.
REQ-035 Start 1 x 1 in cycle 0 and start 2 x 2 in cycle 18, the rdy cycle -> results 1 at cycle 18 and 4 at cycle 36.
